// File: rtl/i2c_reg_arbiter.sv
// Register bank shared by an I2C slave port and a local host port: one access per
// transaction, IDLE -> ACCESS -> RESP, round-robin on contention. Optional macro: I2C_ARB_WPROT_EN.
module i2c_reg_arbiter #(
    parameter int NUM_REGS   = 16,
    parameter int WPROT_REGS = 2
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       i2c_req,
    input  logic       i2c_we,
    input  logic [7:0] i2c_addr,
    input  logic [7:0] i2c_wdata,
    output logic       i2c_ack,
    output logic [7:0] i2c_rdata,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       err,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {OWN_I2C = 1'b0, OWN_HOST = 1'b1} owner_t;

    localparam int         IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NUM_LIM = 9'(NUM_REGS);
    localparam logic [8:0] WP_LIM  = 9'(WPROT_REGS);
`ifdef I2C_ARB_WPROT_EN
    localparam bit WPROT_ON = 1'b1;
`else
    localparam bit WPROT_ON = 1'b0;
`endif

    // Handshake: req/we/addr/wdata are held by the requester from req until its ack
    // is seen; ack is a single-cycle pulse and req must be low again by the next IDLE
    // cycle or it is taken as a fresh request.
    state_t     state_q, state_d;
    owner_t     owner_q, owner_d, last_owner_q, last_owner_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
    logic       i2c_ack_q, i2c_ack_d, host_ack_q, host_ack_d, err_q, err_d;
    logic [7:0] i2c_rdata_q, i2c_rdata_d, host_rdata_q, host_rdata_d;
    logic [7:0] regs_q [NUM_REGS];

    logic             in_range, wprot_hit, reject, grant_i2c, wr_en;
    logic [IDX_W-1:0] idx;
    logic [7:0]       rd_val;

    assign in_range  = {1'b0, addr_q} < NUM_LIM;
    assign idx       = addr_q[IDX_W-1:0];
    assign rd_val    = in_range ? regs_q[idx] : 8'hFF;
    assign wprot_hit = WPROT_ON && (owner_q == OWN_I2C) && we_q && ({1'b0, addr_q} < WP_LIM);
    assign reject    = !in_range || wprot_hit;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i2c_rdata_d  = i2c_rdata_q;
        host_rdata_d = host_rdata_q;
        i2c_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        err_d        = 1'b0;
        wr_en        = 1'b0;
        grant_i2c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i2c_req || host_req) begin
                    // On a tie the port that did not own the previous transaction wins.
                    grant_i2c    = i2c_req && (!host_req || last_owner_q == OWN_HOST);
                    owner_d      = grant_i2c ? OWN_I2C : OWN_HOST;
                    last_owner_d = grant_i2c ? OWN_I2C : OWN_HOST;
                    we_d         = grant_i2c ? i2c_we    : host_we;
                    addr_d       = grant_i2c ? i2c_addr  : host_addr;
                    wdata_d      = grant_i2c ? i2c_wdata : host_wdata;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                err_d   = reject;
                if (we_q) begin
                    wr_en = !reject;
                end else if (owner_q == OWN_I2C) begin
                    i2c_rdata_d = rd_val;
                end else begin
                    host_rdata_d = rd_val;
                end
                i2c_ack_d  = (owner_q == OWN_I2C);
                host_ack_d = (owner_q == OWN_HOST);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_HOST;
            last_owner_q <= OWN_HOST;
            we_q         <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            i2c_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            err_q        <= 1'b0;
            i2c_rdata_q  <= 8'h00;
            host_rdata_q <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i2c_ack_q    <= i2c_ack_d;
            host_ack_q   <= host_ack_d;
            err_q        <= err_d;
            i2c_rdata_q  <= i2c_rdata_d;
            host_rdata_q <= host_rdata_d;
            if (wr_en) regs_q[idx] <= wdata_q;
        end
    end

    assign i2c_ack     = i2c_ack_q;
    assign host_ack    = host_ack_q;
    assign err         = err_q;
    assign i2c_rdata   = i2c_rdata_q;
    assign host_rdata  = host_rdata_q;
    assign dbg_state_o = state_q;
endmodule
